// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS execute-stage issue controller.
// Contents: datapath widths, the 17 alu_control codes, the opcode and funct
// values that map onto them, and the small enums the decoder passes to the
// pipeline (immediate extension select, overflow check kind).
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 5;

    // alu_control codes seen by the external ALU
    localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b00000;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b00001;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 5'b00010;
    localparam logic [CTRL_W-1:0] ALU_SLLV = 5'b00011;
    localparam logic [CTRL_W-1:0] ALU_SRLV = 5'b00100;
    localparam logic [CTRL_W-1:0] ALU_SRAV = 5'b00101;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00110;
    localparam logic [CTRL_W-1:0] ALU_ADDU = 5'b00111;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b01000;
    localparam logic [CTRL_W-1:0] ALU_SUBU = 5'b01001;
    localparam logic [CTRL_W-1:0] ALU_AND  = 5'b01010;
    localparam logic [CTRL_W-1:0] ALU_OR   = 5'b01011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b01100;
    localparam logic [CTRL_W-1:0] ALU_NOR  = 5'b01101;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b01110;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 5'b01111;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 5'b10000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT} imm_sel_e;
    typedef enum logic [1:0] {OVF_NONE, OVF_ADD, OVF_SUB}   ovf_kind_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational MIPS decoder for the execute-stage issue controller.
// Ports:
//   instr    in   32-bit instruction word
//   code     out  alu_control code (ALU_SLL for unsupported instructions)
//   dest     out  destination register (rd for R-type, rt for I-type, 0 if illegal)
//   imm_sel  out  how the second operand is formed (register / sext / zext imm16)
//   illegal  out  unsupported opcode or funct
//   ovf_kind out  which signed-overflow rule applies (none / add / sub)
module alu_decoder
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]   instr,
    output logic [CTRL_W-1:0] code,
    output logic [REG_AW-1:0] dest,
    output imm_sel_e          imm_sel,
    output logic              illegal,
    output ovf_kind_e         ovf_kind
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // rs index and shamt are consumed by the pipeline, not by decode
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the cases infers a latch.
        code     = ALU_SLL;
        dest     = '0;
        imm_sel  = IMM_NONE;
        illegal  = 1'b0;
        ovf_kind = OVF_NONE;

        if (opcode == OP_RTYPE) begin
            dest = instr[15:11];
            case (funct)
                FN_SLL:  code = ALU_SLL;
                FN_SRL:  code = ALU_SRL;
                FN_SRA:  code = ALU_SRA;
                FN_SLLV: code = ALU_SLLV;
                FN_SRLV: code = ALU_SRLV;
                FN_SRAV: code = ALU_SRAV;
                FN_ADD:  begin code = ALU_ADD; ovf_kind = OVF_ADD; end
                FN_ADDU: code = ALU_ADDU;
                FN_SUB:  begin code = ALU_SUB; ovf_kind = OVF_SUB; end
                FN_SUBU: code = ALU_SUBU;
                FN_AND:  code = ALU_AND;
                FN_OR:   code = ALU_OR;
                FN_XOR:  code = ALU_XOR;
                FN_NOR:  code = ALU_NOR;
                FN_SLT:  code = ALU_SLT;
                FN_SLTU: code = ALU_SLTU;
                default: begin illegal = 1'b1; dest = '0; end
            endcase
        end else begin
            dest = instr[20:16];
            case (opcode)
                OP_ADDI:  begin code = ALU_ADD;  imm_sel = IMM_SEXT; ovf_kind = OVF_ADD; end
                OP_ADDIU: begin code = ALU_ADDU; imm_sel = IMM_SEXT; end
                OP_SLTI:  begin code = ALU_SLT;  imm_sel = IMM_SEXT; end
                OP_SLTIU: begin code = ALU_SLTU; imm_sel = IMM_SEXT; end
                OP_ANDI:  begin code = ALU_AND;  imm_sel = IMM_ZEXT; end
                OP_ORI:   begin code = ALU_OR;   imm_sel = IMM_ZEXT; end
                OP_XORI:  begin code = ALU_XOR;  imm_sel = IMM_ZEXT; end
                // the ALU shifts the zero-extended immediate into the upper half
                OP_LUI:   begin code = ALU_LUI;  imm_sel = IMM_ZEXT; end
                default:  begin illegal = 1'b1; dest = '0; end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end for the MIPS integer datapath.
// Two valid/ready stages: D holds decoded operands that drive the external
// ALU combinationally; W captures the ALU result with overflow/illegal flags.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              instruction + register operands handshake
//   in_instr, in_rs_data, in_rt_data
//   alu_rs, alu_rt, alu_control, alu_shamt   registered D-stage ALU inputs
//   alu_out                        combinational ALU result for D operands
//   out_valid/out_ready            writeback handshake
//   out_result, out_dest, out_wen, out_ovf, out_illegal
// Build option: define ALU_FWD_EN to forward in-flight results into the
// source operands at D capture; otherwise operands come only from the
// register-file inputs.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_rs_data,
    input  logic [XLEN-1:0]   in_rt_data,
    output logic [XLEN-1:0]   alu_rs,
    output logic [XLEN-1:0]   alu_rt,
    output logic [CTRL_W-1:0] alu_control,
    output logic [4:0]        alu_shamt,
    input  logic [XLEN-1:0]   alu_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_wen,
    output logic              out_ovf,
    output logic              out_illegal
);

    logic [CTRL_W-1:0] dec_code;
    logic [REG_AW-1:0] dec_dest;
    imm_sel_e          dec_imm_sel;
    logic              dec_illegal;
    ovf_kind_e         dec_ovf_kind;

    logic              d_valid;
    logic [REG_AW-1:0] d_dest;
    logic              d_illegal;
    ovf_kind_e         d_ovf_kind;

    logic              d_ovf;
    logic              d_wen;
    logic              d_adv;
    logic              d_load;
    logic [XLEN-1:0]   src_rs;
    logic [XLEN-1:0]   src_rt;
    logic [XLEN-1:0]   opnd_b;

    alu_decoder u_dec (
        .instr    (in_instr),
        .code     (dec_code),
        .dest     (dec_dest),
        .imm_sel  (dec_imm_sel),
        .illegal  (dec_illegal),
        .ovf_kind (dec_ovf_kind)
    );

    // D empties into W whenever W is empty or being drained this cycle,
    // and D can refill in that same cycle without a bubble.
    assign d_adv    = d_valid && (!out_valid || out_ready);
    assign in_ready = !d_valid || d_adv;
    assign d_load   = in_valid && in_ready;

    // Signed overflow of the D-stage operation, judged on the ALU's wrapped result.
    always_comb begin
        d_ovf = 1'b0;
        case (d_ovf_kind)
            OVF_ADD: d_ovf = (alu_rs[XLEN-1] == alu_rt[XLEN-1]) && (alu_out[XLEN-1] != alu_rs[XLEN-1]);
            OVF_SUB: d_ovf = (alu_rs[XLEN-1] != alu_rt[XLEN-1]) && (alu_out[XLEN-1] != alu_rs[XLEN-1]);
            default: d_ovf = 1'b0;
        endcase
    end

    assign d_wen = !d_illegal && !d_ovf && (d_dest != '0);

`ifdef ALU_FWD_EN
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
    assign rs_idx = in_instr[25:21];
    assign rt_idx = in_instr[20:16];

    // The D entry leaving this edge is newer than W, so it wins.
    always_comb begin
        src_rs = in_rs_data;
        if (rs_idx != '0) begin
            if (d_adv && d_wen && (d_dest == rs_idx))
                src_rs = alu_out;
            else if (out_valid && out_wen && (out_dest == rs_idx))
                src_rs = out_result;
        end
        src_rt = in_rt_data;
        // For I-type, rt is the destination, not a source.
        if ((in_instr[31:26] == OP_RTYPE) && (rt_idx != '0)) begin
            if (d_adv && d_wen && (d_dest == rt_idx))
                src_rt = alu_out;
            else if (out_valid && out_wen && (out_dest == rt_idx))
                src_rt = out_result;
        end
    end
`else
    assign src_rs = in_rs_data;
    assign src_rt = in_rt_data;
`endif

    always_comb begin
        case (dec_imm_sel)
            IMM_SEXT: opnd_b = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
            IMM_ZEXT: opnd_b = {{(XLEN-16){1'b0}}, in_instr[15:0]};
            default:  opnd_b = src_rt;
        endcase
    end

    // D stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid     <= 1'b0;
            alu_rs      <= '0;
            alu_rt      <= '0;
            alu_control <= '0;
            alu_shamt   <= '0;
            d_dest      <= '0;
            d_illegal   <= 1'b0;
            d_ovf_kind  <= OVF_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values,
            // which is what lets D->W and a new D capture share one edge safely.
            if (d_load) begin
                d_valid     <= 1'b1;
                alu_rs      <= src_rs;
                alu_rt      <= opnd_b;
                alu_control <= dec_code;
                alu_shamt   <= in_instr[10:6];
                d_dest      <= dec_dest;
                d_illegal   <= dec_illegal;
                d_ovf_kind  <= dec_ovf_kind;
            end else if (d_adv) begin
                d_valid <= 1'b0;
            end
        end
    end

    // W stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_dest    <= '0;
            out_wen     <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (d_adv) begin
            out_valid   <= 1'b1;
            out_result  <= alu_out;
            out_dest    <= d_dest;
            out_wen     <= d_wen;
            out_ovf     <= d_ovf;
            out_illegal <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage front end for the MIPS integer datapath.
- Decodes an instruction into the 5-bit alu_control code, shamt and operands.
- Holds these in a decode register that drives the external ALU combinationally.
- Captures the ALU result into a writeback register, with signed-overflow and illegal-instruction detection.
- Two-stage valid/ready pipeline (D, W) between the register-read stage and the register-file write port.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  decode register can accept.
- in_instr  in  32  MIPS instruction word.
- in_rs_data  in  32  register-file value of instr[25:21].
- in_rt_data  in  32  register-file value of instr[20:16].
- alu_rs  out  32  ALU operand rs (registered, D stage).
- alu_rt  out  32  ALU operand rt / immediate (registered).
- alu_control  out  5  ALU operation code (registered).
- alu_shamt  out  5  shift amount, instr[10:6] (registered).
- alu_out  in  32  combinational ALU result for the D-stage operands.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  consumer accepts the writeback entry.
- out_result  out  32  registered ALU result.
- out_dest  out  5  destination register.
- out_wen  out  1  register write enable.
- out_ovf  out  1  signed-overflow exception (add/addi/sub).
- out_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset: all outputs and internal registers are 0, including d_valid, out_valid and alu_control; in_ready=1.
- Handshake:
  - Transfer on valid&ready at a rising edge.
  - out_valid holds with stable data until out_ready.
  - D advances to W when d_valid & (!out_valid | out_ready).
  - in_ready = !d_valid | D advancing (combinational, no bubble).
  - Full throughput of 1 instruction per cycle; latency in->out_valid is 2 cycles.
- Decode, R-type (opcode 0), funct -> code:
  - 00 sll=00000, 02 srl=00001, 03 sra=00010, 04 sllv=00011, 06 srlv=00100, 07 srav=00101.
  - 20 add=00110, 21 addu=00111, 22 sub=01000, 23 subu=01001.
  - 24 and=01010, 25 or=01011, 26 xor=01100, 27 nor=01101, 2A slt=01110, 2B sltu=01111.
  - dest=rd.
- Decode, I-type, opcode -> code:
  - 08 addi=add, 09 addiu=addu, 0A slti=slt, 0B sltiu=sltu: alu_rt = sign-extended imm16.
  - 0C andi=and, 0D ori=or, 0E xori=xor: alu_rt = zero-extended imm16.
  - 0F lui=10000.
  - dest=rt.
- Illegal:
  - Any other opcode/funct: alu_control=00000 with operands passed through.
  - Sets out_illegal=1 and out_wen=0.
- Overflow, computed in W from the D operands and alu_out:
  - add/addi: rs[31]==b[31] & r[31]!=rs[31].
  - sub: rs[31]!=rt[31] & r[31]!=rs[31].
  - On overflow: out_ovf=1, out_wen=0; out_result still carries the wrapped sum.
  - addu/subu/addiu never flag.
- out_wen = !illegal & !ovf & (dest!=0).
- Result bits use 32-bit wrap-around arithmetic; no saturation.
- Simultaneous D->W move and new capture at the same edge is legal and must not drop or duplicate entries.
- Asynchronous reset mid-stream: both stages are emptied immediately; an in-flight entry is discarded and not replayed.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: on D capture, each source operand (rs, and rt for R-type) is forwarded when its index is non-zero.
  - Priority 1: the D-stage instruction's alu_out, when that entry is advancing and would write (wen true) to that index.
  - Priority 2: else out_result, when out_valid & out_wen & out_dest matches.
  - Otherwise the register-file value is used.
- Undefined: operands are taken only from in_rs_data/in_rt_data; hazards are the upstream stage's responsibility.

Decomposition:
- Package alu_pkg holds:
  - the 17 alu_control localparams;
  - opcode and funct constants;
  - XLEN.
- Sub-module alu_decoder (combinational):
  - Inputs: instr.
  - Outputs: code, dest, imm_sel (sext/zext/none), illegal, ovf_kind (none/add/sub).
- alu_issue_ctrl holds the pipeline registers, the handshake, overflow detection and the optional forwarding.

Test Plan:
- Reset, then addu $3,$1,$2 with rs=5, rt=7 -> alu_control=00111 one cycle after accept; out_valid two cycles after; out_result=12, dest=3, wen=1.
- add with rs=0x7FFFFFFF, rt=1 -> out_ovf=1, out_wen=0, out_result=0x80000000; the same operands with addu -> ovf=0, wen=1.
- addi rt=4, imm=0xFFFF, rs=1 -> alu_rt=0xFFFFFFFF, result=0; ori imm=0xFFFF -> alu_rt=0x0000FFFF.
- Opcode 0x3F -> out_illegal=1, wen=0, alu_control=00000; instruction writing $0 -> wen=0.
- Back-to-back stream of 8 instructions with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full; no loss or reordering; out data held stable while stalled.
- ALU_FWD_EN: addu $5 (=10) followed by addu $6,$5,$5 with stale in_rs_data=0 -> result 20; assert rst_n low mid-stream -> out_valid=0 and in_ready=1 immediately.
